// File: rtl/vga_text_shifter.sv
// vga_text_shifter
// Text-mode fetch and pixel serializer for the 32x16 Atom text screen.
// For each displayed scan line it fetches one character code per cell from
// video RAM and looks up that cell's row pattern. The pattern comes from the
// character generator, or from the built-in 2x3 semigraphic block decode.
// Each pattern is then shifted out one pixel per pix_ce tick.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_ce       pixel clock enable; all state advances only when high
//   frame_start  resets glyph row and text row (qualified by pix_ce)
//   line_start   starts fetch/serialization of one scan line (qualified by pix_ce)
//   vram_addr    video RAM byte address {text_row, col}
//   vram_data    video RAM data, valid one pix_ce tick after vram_addr
//   cg_addr      {char_q[5:0], glyph_row} to the character generator
//   cg_data      glyph row pattern, MSB = leftmost pixel
//   pixel        serialized pixel (registered)
//   pixel_valid  high while a visible pixel is on pixel
//
// state  | meaning
// IDLE   | no line in progress, outputs blank
// LEAD   | fetching the first cell, outputs still blank
// ACTIVE | shifting out pixels while the next cell is fetched

module vga_text_shifter #(
  parameter int LINES_PER_ROW = 12,
  parameter int COLS          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic       frame_start,
  input  logic       line_start,
  output logic [8:0] vram_addr,
  input  logic [7:0] vram_data,
  output logic [9:0] cg_addr,
  input  logic [7:0] cg_data,
  output logic       pixel,
  output logic       pixel_valid
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_ACTIVE} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_p;
  logic [5:0] r_col;
  logic [3:0] r_glyph_row;
  logic [3:0] r_text_row;
  logic [7:0] r_char_q;
  logic [7:0] r_pattern_q;
  logic [7:0] r_shreg;
  logic [8:0] r_vram_addr;
  logic       r_pixel;
  logic       r_pixel_valid;

  logic       w_last_cell;
  logic       w_row_adv;
  logic [5:0] w_row_x3;
  logic [5:0] w_band;
  logic       w_blk_l, w_blk_r;
  logic [7:0] w_pattern;

  // The final p=7 of ACTIVE is when the last cell's last pixel goes out; col
  // already points one past the cell being shown, hence the compare with COLS.
  assign w_last_cell = (r_state == S_ACTIVE) && (r_p == 3'd7) && (r_col == 6'(COLS));
  assign w_row_adv   = pix_ce && !line_start && !frame_start && w_last_cell;

  // Semigraphic band: 0 top, 1 middle, 2 bottom third of the text row.
  assign w_row_x3 = 6'(r_glyph_row) * 6'd3;
  assign w_band   = w_row_x3 / 6'(LINES_PER_ROW);

  always_comb begin
    w_blk_l = r_char_q[1];
    w_blk_r = r_char_q[0];
    case (w_band)
      6'd0: begin w_blk_l = r_char_q[5]; w_blk_r = r_char_q[4]; end
      6'd1: begin w_blk_l = r_char_q[3]; w_blk_r = r_char_q[2]; end
      default: ;
    endcase
  end

  assign w_pattern = r_char_q[6] ? {{4{w_blk_l}}, {4{w_blk_r}}}
                                 : (cg_data ^ {8{r_char_q[7]}});

  always_comb begin
    w_state_nxt = r_state;
    if (pix_ce) begin
      if (line_start)
        w_state_nxt = S_LEAD;
      else if (frame_start)
        w_state_nxt = S_IDLE;
      else if (r_state == S_LEAD && r_p == 3'd7)
        w_state_nxt = S_ACTIVE;
      else if (w_last_cell)
        w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p           <= '0;
      r_col         <= '0;
      r_glyph_row   <= '0;
      r_text_row    <= '0;
      r_char_q      <= '0;
      r_pattern_q   <= '0;
      r_shreg       <= '0;
      r_vram_addr   <= '0;
      r_pixel       <= 1'b0;
      r_pixel_valid <= 1'b0;
    end else if (pix_ce) begin
      // frame_start wins over row advance; line_start then restarts at row 0
      if (frame_start) begin
        r_glyph_row <= '0;
        r_text_row  <= '0;
      end else if (w_row_adv) begin
        if (r_glyph_row == 4'(LINES_PER_ROW - 1)) begin
          r_glyph_row <= '0;
          r_text_row  <= r_text_row + 4'd1;
        end else begin
          r_glyph_row <= r_glyph_row + 4'd1;
        end
      end

      if (line_start) begin
        r_p           <= '0;
        r_col         <= '0;
        r_shreg       <= '0;
        r_pixel       <= 1'b0;
        r_pixel_valid <= 1'b0;
      end else if (frame_start || r_state == S_IDLE) begin
        r_pixel       <= 1'b0;
        r_pixel_valid <= 1'b0;
      end else begin
        r_p <= r_p + 3'd1;
        case (r_p)
          3'd0: r_vram_addr <= {r_text_row, r_col[4:0]};
          3'd1: r_char_q    <= vram_data;
          3'd2: r_pattern_q <= w_pattern;
          default: ;
        endcase
        if (r_p == 3'd7) begin
          r_shreg <= r_pattern_q;
          r_col   <= r_col + 6'd1;
        end else if (r_state == S_ACTIVE) begin
          r_shreg <= {r_shreg[6:0], 1'b0};
        end
        if (r_state == S_ACTIVE) begin
          r_pixel       <= r_shreg[7];
          r_pixel_valid <= 1'b1;
        end else begin
          r_pixel       <= 1'b0;
          r_pixel_valid <= 1'b0;
        end
      end
    end
  end

  assign vram_addr   = r_vram_addr;
  assign cg_addr     = {r_char_q[5:0], r_glyph_row};
  assign pixel       = r_pixel;
  assign pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_vga_text_shifter.sv
module tb_vga_text_shifter;
  localparam int LPR = 12;
  localparam int NC  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic       frame_start = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] vram_addr;
  logic [7:0] vram_data;
  logic [9:0] cg_addr;
  logic [7:0] cg_data;
  logic       pixel;
  logic       pixel_valid;

  logic [7:0] vram [512];
  logic [7:0] rom  [1024];

  assign vram_data = vram[vram_addr];
  assign cg_data   = rom[cg_addr];

  vga_text_shifter #(.LINES_PER_ROW(LPR), .COLS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .frame_start(frame_start), .line_start(line_start),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .cg_addr(cg_addr), .cg_data(cg_data),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int m_gr  = 0;
  int m_tr  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pix_ce tick, optionally preceded by a disabled cycle carrying junk pulses.
  task automatic tick(input logic ls, input logic fs);
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      pix_ce      = 1'b0;
      line_start  = 1'($urandom);
      frame_start = 1'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    pix_ce      = 1'b1;
    line_start  = ls;
    frame_start = fs;
    @(posedge clk); #1;
  endtask

  // Reference row pattern of one cell, straight from the display rules.
  function automatic logic [7:0] exp_pat(input logic [7:0] code, input int g);
    int band;
    logic l, r;
    logic [9:0] a;
    if (!code[6]) begin
      a = {code[5:0], 4'(g)};
      return rom[a] ^ (code[7] ? 8'hFF : 8'h00);
    end
    band = (g * 3) / LPR;
    l = code[5 - 2 * band];
    r = code[4 - 2 * band];
    return {{4{l}}, {4{r}}};
  endfunction

  // cut = 0: full line; otherwise stop after cut ticks (line left unfinished).
  task automatic run_line(input logic fs, input int cut);
    logic [7:0] pat;
    logic [7:0] code;
    int k, b;
    logic exp_v;
    if (fs) begin m_gr = 0; m_tr = 0; end
    tick(1'b1, fs);
    chk("start_valid", 32'(pixel_valid), 32'd0);
    for (int t = 1; t <= 266; t++) begin
      if (cut != 0 && t > cut) break;
      tick(1'b0, 1'b0);
      exp_v = (t >= 9 && t <= 8 + NC * 8);
      chk("valid", 32'(pixel_valid), 32'(exp_v));
      if (exp_v) begin
        k = (t - 9) / 8;
        b = (t - 9) % 8;
        pat = exp_pat(vram[m_tr * NC + k], m_gr);
        chk("pixel", 32'(pixel), 32'(pat[7 - b]));
      end else begin
        chk("pixel_blank", 32'(pixel), 32'd0);
      end
      if (t <= 1 + 8 * (NC - 1) && (t - 1) % 8 == 0)
        chk("vram_addr", 32'(vram_addr), 32'(m_tr * NC + (t - 1) / 8));
      if (t >= 2 && t <= 2 + 8 * (NC - 1) && (t - 2) % 8 == 0) begin
        code = vram[m_tr * NC + (t - 2) / 8];
        chk("cg_addr", 32'(cg_addr), 32'({code[5:0], 4'(m_gr)}));
      end
    end
    if (cut == 0) begin
      m_gr++;
      if (m_gr == LPR) begin m_gr = 0; m_tr = (m_tr + 1) % 16; end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[{6'd1, 4'd3}] = 8'h08;
    for (int i = 0; i < 512; i++) vram[i] = 8'h01;
    vram[5] = 8'h81;
    vram[7] = 8'h64;
    for (int i = 32; i < 64; i++) vram[i] = 8'($urandom);

    // held in reset with enable and pulses toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pix_ce = 1'($urandom); line_start = 1'($urandom); frame_start = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_valid", 32'(pixel_valid), 32'd0);
      chk("rst_addr", 32'(vram_addr), 32'd0);
    end
    @(negedge clk);
    pix_ce = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    rst_n = 1'b1;

    // free-running with no line_start: output stays blank
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      chk("idle_valid", 32'(pixel_valid), 32'd0);
      chk("idle_pixel", 32'(pixel), 32'd0);
      chk("idle_addr", 32'(vram_addr), 32'd0);
      chk("idle_cg", 32'(cg_addr), 32'd0);
    end

    // frame, then a full text row of 12 lines, then the next row starts
    tick(1'b0, 1'b1); m_gr = 0; m_tr = 0;
    for (int i = 0; i < LPR; i++) run_line(1'b0, 0);
    run_line(1'b0, 0);                 // text row 1, glyph row 0
    run_line(1'b0, 50);                // aborted, must not advance
    run_line(1'b0, 0);                 // glyph row 1
    run_line(1'b0, 150);               // cut short mid-ACTIVE
    run_line(1'b0, 0);                 // glyph row 2

    // random screen contents
    for (int i = 0; i < 512; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) run_line(1'b0, 0);

    // frame_start mid-line blanks the output and rewinds rows
    run_line(1'b0, 120);
    tick(1'b0, 1'b1); m_gr = 0; m_tr = 0;
    chk("fs_valid", 32'(pixel_valid), 32'd0);
    run_line(1'b0, 0);
    run_line(1'b1, 0);                 // frame and line on the same tick

    // asynchronous reset while pixels are streaming
    run_line(1'b1, 100);
    chk("pre_rst_valid", 32'(pixel_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(pixel_valid), 32'd0);
    chk("async_pixel", 32'(pixel), 32'd0);
    chk("async_addr", 32'(vram_addr), 32'd0);
    chk("async_cg", 32'(cg_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pix_ce = 1'b1; line_start = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(pixel_valid), 32'd0);
    end
    @(negedge clk);
    pix_ce = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    rst_n = 1'b1;
    m_gr = 0; m_tr = 0;
    run_line(1'b1, 0);
    run_line(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_text_shifter.md
Name: vga_text_shifter

Overview:
- Text-mode fetch and pixel serializer for the VGA path; sits directly downstream of the character generator ROM.
- Reads character codes from video RAM and drives the glyph ROM address {code[5:0], glyph row[3:0]}.
- Serializes the returned 8-bit row pattern, or a built-in semigraphic block pattern, into one pixel per pixel-enable tick.
- Display is 32 columns x 16 text rows, the Atom 512-byte text screen.

Parameters:
LINES_PER_ROW, 12, scan lines per text row; glyph row counter wraps at this value (range 1..16)
COLS, 32, character cells per line

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel clock enable; all state advances only when high
frame_start  in  1  pulse, qualified by pix_ce; resets glyph row and text row to 0
line_start  in  1  pulse, qualified by pix_ce; begins fetch for one displayed scan line
vram_addr  out  9  video RAM byte address = text_row*32 + col
vram_data  in  8  video RAM read data, valid one pix_ce tick after vram_addr
cg_addr  out  10  {char_q[5:0], glyph_row[3:0]} to the character generator
cg_data  in  8  glyph row pattern, combinational from cg_addr, MSB = leftmost pixel
pixel  out  1  serialized pixel, registered
pixel_valid  out  1  high while a visible pixel is on pixel

Behaviour:
- Reset values: all registers 0.
  - Outputs: pixel=0, pixel_valid=0, vram_addr=0, cg_addr=0.
  - Internal: state=IDLE, phase p=0, col=0, glyph_row=0, text_row=0.
- Everything below applies only on clk edges where pix_ce=1.
- States: IDLE, LEAD, ACTIVE.
- line_start (any state, restarts a line in progress):
  - p<=0, col<=0, state<=LEAD, shift register<=0.
  - pixel_valid<=0 on that tick.
- Fetch phases p=0..7, running in LEAD and ACTIVE; p increments each tick and wraps 7->0.
  - p=0: vram_addr<={text_row, col[4:0]}.
  - p=1: char_q<=vram_data.
  - p=2: pattern_q<=decoded pattern (see decode rules).
  - p=7: shreg<=pattern_q; col<=col+1.
    - LEAD: state<=ACTIVE.
    - ACTIVE, cell COLS just finished: state<=IDLE and the row advance below applies.
- Decode rules:
  - char_q[6]=0 (text): pattern=cg_data XOR {8{char_q[7]}}, so bit 7 selects inverse video.
  - char_q[6]=1 (semigraphic 6): band = glyph_row*3/LINES_PER_ROW (0 top, 1 mid, 2 bottom).
    - Left nibble = char_q[5-2*band], replicated to pixels 7..4.
    - Right nibble = char_q[4-2*band], replicated to pixels 3..0.
    - char_q[7] is ignored in this mode.
- Output in ACTIVE:
  - pixel<=shreg[7]; pixel_valid<=1.
  - shreg shifts left, zero fill, on every tick except p=7, which reloads it.
- Output in IDLE and LEAD: pixel<=0, pixel_valid<=0.
- Latency: first valid pixel is registered on the 9th pix_ce tick after the line_start tick. Each line yields exactly COLS*8 valid pixels, then pixel_valid drops.
- Row advance, on the tick ACTIVE->IDLE:
  - glyph_row<=glyph_row+1.
  - If glyph_row==LINES_PER_ROW-1: glyph_row<=0 and text_row<=text_row+1, wrapping mod 16.
- A line cut short by line_start or frame_start does not advance the row.
- frame_start: glyph_row<=0, text_row<=0, state<=IDLE, pixel_valid<=0.
  - frame_start and line_start on the same tick: rows reset first, then the line starts at row 0.
- cg_addr is combinational from char_q and glyph_row; rows >= LINES_PER_ROW are never addressed.
- rst_n low at any time forces reset values immediately; the next line_start after release begins normally.

Test Plan:
- Reset with pix_ce toggling, no line_start -> pixel_valid=0, pixel=0, vram_addr=0 indefinitely.
- VRAM all 0x01 ('A'), frame_start then line_start at glyph_row=3 -> first valid pixel exactly 9 ticks after line_start; 32 repeats of 0,0,0,0,1,0,0,0 (0x08); exactly 256 valid pixels.
- Cell (row 0, col 5)=0x81, glyph_row 3 -> that cell outputs ~0x08=0xF7; other cells unaffected; vram_addr steps 0..31.
- Semigraphic code 0x64 (bits 5=1, 2=1), lines 0, 4, 8 -> patterns 0xF0, 0x0F, 0x00.
- 12 consecutive full lines after frame_start -> text_row advances to 1 and glyph_row returns to 0; vram_addr on the next line is 32..63. A line aborted by a second line_start does not advance glyph_row.
- rst_n asserted mid-line during ACTIVE -> pixel_valid=0 asynchronously; after release plus frame_start and line_start, output is identical to the first line.
